// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the RV32 core, the consumer end of the EX/MEM register.
//
// Issues data-memory accesses over a req/ready handshake, freezes the
// front of the pipeline with stall_o while an access is outstanding, and
// loads the MEM/WB register with the selected write-back value. A
// combinational forwarding tap presents the non-load result to EX.
//
// Optional feature: define MEM_WBUF_EN to add a one-entry posted store
// buffer. A store then retires in one cycle and drains to memory in the
// background. Without the macro, stores stall until dmem_ready, like loads.
//
// Ports
//   clk, rst         clock (rising edge); synchronous active-high reset
//   alu_result_in    ALU result; effective byte address for loads/stores
//   mem_wdata_in     store data
//   rd_in            destination register
//   PC_step_in       link value for jal/jalr
//   memrd_in         load
//   memwr_in         store
//   mem2reg_in       write-back selects load data
//   regwr_in         register write enable
//   jump_in          write-back selects PC_step_in
//   dmem_*           data memory handshake: req/wen/addr/wdata out, rdata/ready in
//   stall_o          combinational; holds PC/IF/ID/EX and the EX/MEM register
//   fwd_valid/rd/dat combinational forwarding tap for EX (never load data)
//   wb_rd/regwr/data MEM/WB register outputs
module mem_stage #(
  parameter int unsigned BIT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIT_W-1:0]  alu_result_in,
  input  logic [BIT_W-1:0]  mem_wdata_in,
  input  logic [4:0]        rd_in,
  input  logic [BIT_W-1:0]  PC_step_in,
  input  logic              memrd_in,
  input  logic              memwr_in,
  input  logic              mem2reg_in,
  input  logic              regwr_in,
  input  logic              jump_in,
  output logic              dmem_req,
  output logic              dmem_wen,
  output logic [BIT_W-3:0]  dmem_addr,
  output logic [BIT_W-1:0]  dmem_wdata,
  input  logic [BIT_W-1:0]  dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_o,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [BIT_W-1:0]  fwd_dat,
  output logic [4:0]        wb_rd,
  output logic              wb_regwr,
  output logic [BIT_W-1:0]  wb_data
);

  localparam int unsigned ADDR_W = BIT_W - 2;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Decoded operation; a load with the store bit also set is treated as a load.
  logic              is_load;
  logic              is_store;
  logic              memop;
  logic              rd_nonzero;
  logic [ADDR_W-1:0] op_addr;
  logic [BIT_W-1:0]  wb_sel;

  assign is_load    = memrd_in;
  assign is_store   = memwr_in & ~memrd_in;
  assign memop      = memrd_in | memwr_in;
  assign rd_nonzero = (rd_in != REG_W'(0));
  assign op_addr    = alu_result_in[BIT_W-1:2];

  // Write-back value selection.
  assign wb_sel = mem2reg_in ? dmem_rdata :
                  jump_in    ? PC_step_in : alu_result_in;

`ifdef MEM_WBUF_EN
  // Posted store buffer; while valid, its drain owns the memory port.
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [BIT_W-1:0]  buf_data_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, memory port drive, stall and forwarding tap.
  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    stall_o    = 1'b0;
    fwd_valid  = 1'b0;
    fwd_rd     = rd_in;
    fwd_dat    = jump_in ? PC_step_in : alu_result_in;

    if (!rst) begin
      fwd_valid = regwr_in & ~memrd_in & rd_nonzero;

`ifdef MEM_WBUF_EN
      if (buf_valid_q) begin
        // Drain in progress: a new store may enter the buffer on the
        // completing edge; a load waits and issues the cycle after.
        dmem_req   = 1'b1;
        dmem_wen   = 1'b1;
        dmem_addr  = buf_addr_q;
        dmem_wdata = buf_data_q;
        stall_o    = memop & ~(is_store & dmem_ready);
      end else if (is_load || (state_q == BUSY)) begin
        dmem_req   = 1'b1;
        dmem_wen   = 1'b0;
        dmem_addr  = op_addr;
        dmem_wdata = mem_wdata_in;
        stall_o    = is_load & ~dmem_ready;
      end
`else
      if (memop || (state_q == BUSY)) begin
        dmem_req   = 1'b1;
        dmem_wen   = is_store;
        dmem_addr  = op_addr;
        dmem_wdata = mem_wdata_in;
        stall_o    = memop & ~dmem_ready;
      end
`endif

      unique case (state_q)
        IDLE: if (dmem_req && !dmem_ready) state_d = BUSY;
        BUSY: if (dmem_ready)              state_d = IDLE;
        default:                           state_d = IDLE;
      endcase
    end
  end

`ifdef MEM_WBUF_EN
  // Buffer fill and drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      if (buf_valid_q && dmem_ready) begin
        buf_valid_q <= 1'b0;
      end
      if (is_store && !stall_o) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= op_addr;
        buf_data_q  <= mem_wdata_in;
      end
    end
  end
`endif

  // MEM/WB register; a stalled cycle inserts a bubble so each instruction
  // writes back exactly once, on the cycle it leaves the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rd    <= '0;
      wb_regwr <= 1'b0;
      wb_data  <= '0;
    end else if (stall_o) begin
      wb_regwr <= 1'b0;
    end else begin
      wb_rd    <= rd_in;
      wb_regwr <= regwr_in & rd_nonzero;
      wb_data  <= wb_sel;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in;
  logic [31:0] mem_wdata_in;
  logic [4:0]  rd_in;
  logic [31:0] PC_step_in;
  logic        memrd_in;
  logic        memwr_in;
  logic        mem2reg_in;
  logic        regwr_in;
  logic        jump_in;
  logic        dmem_req;
  logic        dmem_wen;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall_o;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_dat;
  logic [4:0]  wb_rd;
  logic        wb_regwr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fails  = 0;

  mem_stage #(.BIT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_result_in (alu_result_in),
    .mem_wdata_in  (mem_wdata_in),
    .rd_in         (rd_in),
    .PC_step_in    (PC_step_in),
    .memrd_in      (memrd_in),
    .memwr_in      (memwr_in),
    .mem2reg_in    (mem2reg_in),
    .regwr_in      (regwr_in),
    .jump_in       (jump_in),
    .dmem_req      (dmem_req),
    .dmem_wen      (dmem_wen),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .stall_o       (stall_o),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_dat       (fwd_dat),
    .wb_rd         (wb_rd),
    .wb_regwr      (wb_regwr),
    .wb_data       (wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_result_in = '0;
    mem_wdata_in  = '0;
    rd_in         = '0;
    PC_step_in    = '0;
    memrd_in      = 1'b0;
    memwr_in      = 1'b0;
    mem2reg_in    = 1'b0;
    regwr_in      = 1'b0;
    jump_in       = 1'b0;
    dmem_rdata    = '0;
    dmem_ready    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();

    // Reset state
    chk("rst_req",     32'(dmem_req),   32'h0);
    chk("rst_wen",     32'(dmem_wen),   32'h0);
    chk("rst_addr",    32'(dmem_addr),  32'h0);
    chk("rst_wdata",   dmem_wdata,      32'h0);
    chk("rst_stall",   32'(stall_o),    32'h0);
    chk("rst_fwd_v",   32'(fwd_valid),  32'h0);
    chk("rst_wb_rd",   32'(wb_rd),      32'h0);
    chk("rst_wb_we",   32'(wb_regwr),   32'h0);
    chk("rst_wb_data", wb_data,         32'h0);

    // ALU op rd=5
    rst = 1'b0;
    rd_in = 5'd5; alu_result_in = 32'h1234; regwr_in = 1'b1;
    #1;
    chk("alu_stall",   32'(stall_o),   32'h0);
    chk("alu_req",     32'(dmem_req),  32'h0);
    chk("alu_fwd_v",   32'(fwd_valid), 32'h1);
    chk("alu_fwd_rd",  32'(fwd_rd),    32'h5);
    chk("alu_fwd_dat", fwd_dat,        32'h1234);
    tick();
    chk("alu_wb_rd",   32'(wb_rd),     32'h5);
    chk("alu_wb_we",   32'(wb_regwr),  32'h1);
    chk("alu_wb_data", wb_data,        32'h1234);

    // Load from 0x100, three wait cycles
    clear_inputs();
    rd_in = 5'd7; alu_result_in = 32'h100; memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1;
    #1;
    chk("ld_req",   32'(dmem_req),  32'h1);
    chk("ld_wen",   32'(dmem_wen),  32'h0);
    chk("ld_addr",  32'(dmem_addr), 32'h40);
    chk("ld_fwd_v", 32'(fwd_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_stall", 32'(stall_o),  32'h1);
      chk("ld_wait_req",   32'(dmem_req), 32'h1);
      tick();
      chk("ld_bubble", 32'(wb_regwr), 32'h0);
    end
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_done_stall", 32'(stall_o),   32'h0);
    chk("ld_done_addr",  32'(dmem_addr), 32'h40);
    tick();
    chk("ld_wb_data", wb_data,        32'hDEADBEEF);
    chk("ld_wb_we",   32'(wb_regwr),  32'h1);
    chk("ld_wb_rd",   32'(wb_rd),     32'h7);
    clear_inputs();
    tick();
    chk("ld_once", 32'(wb_regwr), 32'h0);

    // jal rd=1, then rd=0
    rd_in = 5'd1; jump_in = 1'b1; PC_step_in = 32'h2004; alu_result_in = 32'h55; regwr_in = 1'b1;
    #1;
    chk("jal_fwd_dat", fwd_dat,        32'h2004);
    chk("jal_fwd_v",   32'(fwd_valid), 32'h1);
    tick();
    chk("jal_wb_data", wb_data,        32'h2004);
    chk("jal_wb_we",   32'(wb_regwr),  32'h1);
    rd_in = 5'd0;
    #1;
    chk("jal0_fwd_v",  32'(fwd_valid), 32'h0);
    tick();
    chk("jal0_wb_we",  32'(wb_regwr),  32'h0);

    // Load and store both set: handled as a load
    clear_inputs();
    memrd_in = 1'b1; memwr_in = 1'b1; alu_result_in = 32'h10; dmem_ready = 1'b1;
    #1;
    chk("ill_req",   32'(dmem_req),  32'h1);
    chk("ill_wen",   32'(dmem_wen),  32'h0);
    chk("ill_addr",  32'(dmem_addr), 32'h4);
    chk("ill_stall", 32'(stall_o),   32'h0);
    tick();

    // Reset while a load is outstanding
    clear_inputs();
    rd_in = 5'd9; alu_result_in = 32'h204; memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1;
    tick();
    chk("rb_req",  32'(dmem_req),  32'h1);
    chk("rb_addr", 32'(dmem_addr), 32'h81);
    rst = 1'b1;
    tick();
    chk("rb_req_drop", 32'(dmem_req),  32'h0);
    chk("rb_no_wb",    32'(wb_regwr),  32'h0);
    rst = 1'b0;
    clear_inputs();
    dmem_ready = 1'b1; dmem_rdata = 32'hBADBAD00;
    tick();
    chk("rb_after_req",  32'(dmem_req), 32'h0);
    chk("rb_after_we",   32'(wb_regwr), 32'h0);
    chk("rb_after_data", wb_data,       32'h0);

    // sw 0xAA to 0x200, then lw from 0x300; memory answers 2 cycles late
    clear_inputs();
    memwr_in = 1'b1; alu_result_in = 32'h200; mem_wdata_in = 32'hAA;
    #1;
`ifdef MEM_WBUF_EN
    chk("sw_stall", 32'(stall_o),  32'h0);
    chk("sw_req",   32'(dmem_req), 32'h0);
    tick();
    clear_inputs();
    memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd3; alu_result_in = 32'h300;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("drain_stall", 32'(stall_o),    32'h1);
      chk("drain_wen",   32'(dmem_wen),   32'h1);
      chk("drain_addr",  32'(dmem_addr),  32'h80);
      chk("drain_wdata", dmem_wdata,      32'hAA);
      tick();
      chk("drain_bubble", 32'(wb_regwr),  32'h0);
    end
    dmem_ready = 1'b1;
    #1;
    chk("drain_done_stall", 32'(stall_o), 32'h1);
    tick();
    dmem_ready = 1'b0;
    #1;
`else
    for (int i = 0; i < 2; i++) begin
      chk("sw_stall", 32'(stall_o),   32'h1);
      chk("sw_wen",   32'(dmem_wen),  32'h1);
      chk("sw_addr",  32'(dmem_addr), 32'h80);
      chk("sw_wdata", dmem_wdata,     32'hAA);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("sw_done_stall", 32'(stall_o), 32'h0);
    tick();
    chk("sw_wb_we", 32'(wb_regwr), 32'h0);
    clear_inputs();
    memrd_in = 1'b1; mem2reg_in = 1'b1; regwr_in = 1'b1; rd_in = 5'd3; alu_result_in = 32'h300;
    #1;
`endif
    for (int i = 0; i < 2; i++) begin
      chk("lw_stall", 32'(stall_o),   32'h1);
      chk("lw_wen",   32'(dmem_wen),  32'h0);
      chk("lw_addr",  32'(dmem_addr), 32'hC0);
      tick();
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("lw_done_stall", 32'(stall_o), 32'h0);
    tick();
    chk("lw_wb_data", wb_data,       32'h12345678);
    chk("lw_wb_rd",   32'(wb_rd),    32'h3);
    chk("lw_wb_we",   32'(wb_regwr), 32'h1);
    clear_inputs();
    tick();
    chk("end_req", 32'(dmem_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
